// File: rtl/ripple_adder_6bit.sv
// Registered ripple-carry adder. The carry chain is built explicitly from
// full-adder cells, and sum, carry-out and signed overflow appear one cycle after in_valid.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_adder_6bit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             out_valid_reg;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      full_adder_cell u_fa (
        .a  (x[gi]),
        .b  (y[gi]),
        .ci (c[gi]),
        .s  (s[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // Result registers update only on valid cycles; out_valid tracks the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg      <= s;
        cout_reg     <= c[WIDTH];
        overflow_reg <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;
  assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_ripple_adder_6bit.sv
// Self-checking bench for ripple_adder_6bit. It covers directed vectors, hold and reset
// sequences, and random traffic checked against an arithmetic reference model.

module tb_ripple_adder_6bit;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         out_valid;

  int total = 0;
  int bad = 0;

  ripple_adder_6bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [9];

  // Expected values come from plain arithmetic, with unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int u;
    int sv;
    u  = int'(a) + int'(b) + int'(ci);
    sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
    es = W'(u % 64);
    ec = (u >= 64);
    eo = (sv > 31) || (sv < -32);
  endtask

  task automatic check(input string name, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic ev);
    total++;
    if (sum !== es || cout !== ec || overflow !== eo || out_valid !== ev) begin
      bad++;
      $display("FAIL %s: got sum=%0d cout=%0b ovf=%0b vld=%0b, want sum=%0d cout=%0b ovf=%0b vld=%0b",
               name, sum, cout, overflow, out_valid, es, ec, eo, ev);
    end else begin
      $display("ok   %s: sum=%0d cout=%0b ovf=%0b vld=%0b", name, sum, cout, overflow, out_valid);
    end
  endtask

  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;
  logic         m_vld;

  initial begin
    vecs[0] = '{6'd1,  6'd0,  1'b0, 6'd1,  1'b0, 1'b0};
    vecs[1] = '{6'd1,  6'd1,  1'b0, 6'd2,  1'b0, 1'b0};
    vecs[2] = '{6'd63, 6'd1,  1'b0, 6'd0,  1'b1, 1'b0};
    vecs[3] = '{6'd63, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0};
    vecs[4] = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0, 1'b1};
    vecs[5] = '{6'd32, 6'd32, 1'b0, 6'd0,  1'b1, 1'b1};
    vecs[6] = '{6'd20, 6'd25, 1'b1, 6'd46, 1'b0, 1'b1};
    vecs[7] = '{6'd48, 6'd40, 1'b0, 6'd24, 1'b1, 1'b1};
    vecs[8] = '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0;

    // Asynchronous reset asserted between edges.
    #2 rst_n = 1'b0;
    #1 check("reset_async", 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_idle", 6'd0, 1'b0, 1'b0, 1'b0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      x = vecs[i].a; y = vecs[i].b; cin = vecs[i].ci; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_%0d+%0d+%0d", i, vecs[i].a, vecs[i].b, vecs[i].ci),
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 1'b1);
      in_valid = 1'b0;
    end

    // Back-to-back, hold, then reset with a result in flight.
    @(negedge clk);
    x = 6'd1; y = 6'd2; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("b2b_1+2", 6'd3, 1'b0, 1'b0, 1'b1);
    x = 6'd3; y = 6'd4;
    @(negedge clk);
    check("b2b_3+4", 6'd7, 1'b0, 1'b0, 1'b1);
    x = 6'd10; y = 6'd20;
    @(negedge clk);
    check("b2b_10+20", 6'd30, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; x = 'x; y = 'x; cin = 1'bx;
    @(negedge clk);
    check("hold_30", 6'd30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_30_xin", 6'd30, 1'b0, 1'b0, 1'b0);
    x = 6'd5; y = 6'd6; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_cycle", 6'd0, 1'b0, 1'b0, 1'b0);
    x = 6'd9; y = 6'd9;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("inflight_discarded", 6'd0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
    for (int n = 0; n < 300; n++) begin
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) model(x, y, cin, m_sum, m_cout, m_ovf);
      m_vld = in_valid;
      @(negedge clk);
      check($sformatf("rand%0d", n), m_sum, m_cout, m_ovf, m_vld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
